// File: rtl/offset_frame_sequencer_if.sv
// Load, control and offset-bank write bundle of the offset frame sequencer.
// The master side is the command parser / top level; the slave side is the sequencer.
interface offset_frame_sequencer_if #(
  parameter int OFFSET_WIDTH = 11,
  parameter int FRAMES       = 4,
  parameter int PERIOD_WIDTH = 16
);
  localparam int FW = $clog2(FRAMES);
  localparam int DW = OFFSET_WIDTH + 1;

  // Frame-store load port
  logic                    ld_valid;
  logic                    ld_ready;
  logic [FW-1:0]           ld_frame;
  logic [6:0]              ld_index;
  logic [DW-1:0]           ld_data;

  // Playback control and configuration
  logic                    start;
  logic                    stop;
  logic [FW-1:0]           cfg_last_frame;
  logic [PERIOD_WIDTH-1:0] cfg_period;
  logic                    main_clk_fall;

  // Offset bank write side and status
  logic                    wr_en;
  logic [6:0]              wr_index;
  logic [DW-1:0]           wr_data;
  logic                    reload_req;
  logic [FW-1:0]           frame_idx;
  logic                    busy;
  logic                    overrun;

  modport master (
    output ld_valid, ld_frame, ld_index, ld_data,
    output start, stop, cfg_last_frame, cfg_period, main_clk_fall,
    input  ld_ready, wr_en, wr_index, wr_data, reload_req, frame_idx, busy, overrun
  );

  modport slave (
    input  ld_valid, ld_frame, ld_index, ld_data,
    input  start, stop, cfg_last_frame, cfg_period, main_clk_fall,
    output ld_ready, wr_en, wr_index, wr_data, reload_req, frame_idx, busy, overrun
  );
endinterface

// File: rtl/offset_frame_sequencer.sv
// Offset frame sequencer: stores FRAMES frames of per-transducer {enable, offset}
// entries, streams one frame into the shadow offset bank, then requests a reload
// on a main-clock falling edge so every transducer switches pattern together.
module offset_frame_sequencer #(
  parameter int OUTPUTS      = 88,
  parameter int OFFSET_WIDTH = 11,
  parameter int FRAMES       = 4,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  offset_frame_sequencer_if.slave  bus
);

  localparam int FW    = $clog2(FRAMES);
  localparam int DW    = OFFSET_WIDTH + 1;
  localparam int PW    = PERIOD_WIDTH;
  localparam int IW    = 7;
  localparam int DEPTH = FRAMES * OUTPUTS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(OUTPUTS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ARM    = 2'd2
  } state_t;

  // Saturating increment for the fall counter.
  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (&v) ? v : v + PW'(1);
  endfunction

  // A programmed period of zero behaves as one fall per reload.
  function automatic logic [PW:0] eff_period(input logic [PW-1:0] p);
    return (p == '0) ? (PW+1)'(1) : {1'b0, p};
  endfunction

  // Next frame to play; the last-frame setting is clamped to the store size and
  // any frame at or beyond it wraps back to frame 0.
  function automatic logic [FW-1:0] next_frame(input logic [FW-1:0] cur,
                                               input logic [FW-1:0] last);
    logic [FW-1:0] last_eff;
    last_eff = (int'(last) > FRAMES - 1) ? FW'(FRAMES - 1) : last;
    return (cur >= last_eff) ? '0 : cur + FW'(1);
  endfunction

  state_t          state;
  logic            first;
  logic [PW-1:0]   fall_cnt;
  logic [FW-1:0]   frame_idx_q;
  logic [CW-1:0]   cnt;
  logic            wr_en_q;
  logic [IW-1:0]   wr_index_q;
  logic [DW-1:0]   wr_data_q;
  logic            reload_q;
  logic            overrun_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            ld_ready;
  logic            mem_we;
  logic            rd_en;
  logic [AW-1:0]   ld_addr;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   mem_addr;
  logic [PW-1:0]   fall_cnt_inc;
  logic [PW:0]     period_eff;
  logic            due;

  // The single RAM port belongs to playback while streaming, to the loader otherwise.
  assign ld_ready     = (state != STREAM);
  assign mem_we       = bus.ld_valid && ld_ready && (bus.ld_index < IW'(OUTPUTS));
  assign rd_en        = (state == STREAM) && (cnt < CW'(OUTPUTS)) && !bus.stop;
  assign ld_addr      = AW'(bus.ld_frame) * AW'(OUTPUTS) + AW'(bus.ld_index);
  assign rd_addr      = AW'(frame_idx_q) * AW'(OUTPUTS) + AW'(cnt);
  assign mem_addr     = rd_en ? rd_addr : ld_addr;

  // Fall accounting: a fall is due on the very first reload after start, or once
  // this fall brings the count up to the programmed period.
  assign fall_cnt_inc = bus.main_clk_fall ? sat_inc(fall_cnt) : fall_cnt;
  assign period_eff   = eff_period(bus.cfg_period);
  assign due          = first || (({1'b0, fall_cnt} + (PW+1)'(1)) >= period_eff);

  // Frame store write: no reset so contents survive rst and map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= bus.ld_data;
    end
  end

  // Frame store read: one-cycle latency, the read register is the bank write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_data_q <= '0;
    end else if (rd_en) begin
      wr_data_q <= mem[mem_addr];
    end
  end

  // Playback FSM: stream a frame, arm, fire the reload on a due fall, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      first       <= 1'b0;
      fall_cnt    <= '0;
      frame_idx_q <= '0;
      cnt         <= '0;
      wr_en_q     <= 1'b0;
      wr_index_q  <= '0;
      reload_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      reload_q <= 1'b0;
      wr_en_q  <= rd_en;
      if (rd_en) begin
        wr_index_q <= IW'(cnt);
      end

      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state       <= STREAM;
            frame_idx_q <= '0;
            fall_cnt    <= '0;
            first       <= 1'b1;
            cnt         <= '0;
            overrun_q   <= 1'b0;
          end
        end

        STREAM: begin
          if (bus.stop) begin
            state <= IDLE;
          end else begin
            fall_cnt <= fall_cnt_inc;
            if (cnt == CW'(OUTPUTS)) begin
              // Last write is on the bank this cycle; the reload window has
              // already passed if enough falls went by while streaming.
              state <= ARM;
              if (!first && ({1'b0, fall_cnt_inc} >= period_eff)) begin
                overrun_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        ARM: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (bus.main_clk_fall) begin
            if (due) begin
              reload_q    <= 1'b1;
              first       <= 1'b0;
              fall_cnt    <= '0;
              frame_idx_q <= next_frame(frame_idx_q, bus.cfg_last_frame);
              cnt         <= '0;
              state       <= STREAM;
            end else begin
              fall_cnt <= fall_cnt_inc;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_index   = wr_index_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.reload_req = reload_q;
  assign bus.frame_idx  = frame_idx_q;
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_offset_frame_sequencer.sv
// Directed bench for offset_frame_sequencer: a vector table for the idle/load/
// start/stop handshake plus hand-written playback, overrun and stall sequences.
module tb_offset_frame_sequencer;

  localparam int OUTPUTS = 88;
  localparam int OW      = 11;
  localparam int FRAMES  = 4;
  localparam int PW      = 16;

  logic clk;
  logic rst;

  offset_frame_sequencer_if #(.OFFSET_WIDTH(OW), .FRAMES(FRAMES), .PERIOD_WIDTH(PW)) bus ();

  offset_frame_sequencer #(
    .OUTPUTS(OUTPUTS), .OFFSET_WIDTH(OW), .FRAMES(FRAMES), .PERIOD_WIDTH(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  frame;
    logic [6:0]  index;
    logic [11:0] data;
    logic        start;
    logic        stop;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_wr_en;
    logic [6:0]  exp_wr_index;
    logic        exp_reload;
  } vec_t;

  vec_t        vecs [8];
  logic [11:0] model [FRAMES][OUTPUTS];

  int tests       = 0;
  int fails       = 0;
  int cyc         = 0;
  int fall_gap    = 0;
  int fall_cnt_tb = 0;
  bit prev_fall   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: outputs are read 1 ns after the edge; pulses are cleared and the
  // periodic main-clock fall is generated for the following edge.
  task automatic tick();
    prev_fall = bus.main_clk_fall;
    @(posedge clk);
    #1;
    if (prev_fall) fall_cnt_tb++;
    cyc++;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.main_clk_fall = (fall_gap > 0) && ((cyc % fall_gap) == 0);
  endtask

  task automatic load(input int f, input int idx, input logic [11:0] d);
    int n;
    n = 0;
    bus.ld_valid = 1'b1;
    bus.ld_frame = 2'(f);
    bus.ld_index = 7'(idx);
    bus.ld_data  = d;
    while (!bus.ld_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("load_ready_timeout", 32'(n), 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    if (idx < OUTPUTS) model[f][idx] = d;
  endtask

  task automatic wait_reload(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.reload_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("reload_seen", 32'(seen), 32'd1);
    check("reload_after_fall", 32'(prev_fall), 32'd1);
  endtask

  // Checks one full frame on the bank port; optionally injects a fall while
  // entry inj_at is on the port. Returns with the DUT in its first ARM cycle.
  task automatic check_stream(input int f, input int inj_at);
    int n;
    n = 0;
    while (!bus.wr_en && n < 8) begin
      tick();
      n++;
    end
    check("stream_start", 32'(bus.wr_en), 32'd1);
    check("stream_frame_idx", 32'(bus.frame_idx), 32'(f));
    for (int i = 0; i < OUTPUTS; i++) begin
      check("wr_en", 32'(bus.wr_en), 32'd1);
      check("wr_index", 32'(bus.wr_index), 32'(i));
      check("wr_data", 32'(bus.wr_data), 32'(model[f][i]));
      if (i == inj_at) bus.main_clk_fall = 1'b1;
      tick();
    end
    check("stream_end_wr_en", 32'(bus.wr_en), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int stall;
    bit seen;

    //                valid frame index data     start stop  rdy  busy wr  widx  rl
    vecs[0] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 7'd100, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 7'd0,   12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 1'b0};

    rst                = 1'b1;
    bus.ld_valid       = 1'b0;
    bus.ld_frame       = '0;
    bus.ld_index       = '0;
    bus.ld_data        = '0;
    bus.start          = 1'b0;
    bus.stop           = 1'b0;
    bus.cfg_last_frame = '0;
    bus.cfg_period     = 16'd1;
    bus.main_clk_fall  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_reload", 32'(bus.reload_req), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_idx", 32'(bus.frame_idx), 32'd0);
    check("rst_wr_index", 32'(bus.wr_index), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Frame 0 holds data = index, frame 1 holds distinct enabled offsets
    for (int i = 0; i < OUTPUTS; i++) load(0, i, 12'(i));
    for (int i = 0; i < OUTPUTS; i++) load(1, i, 12'h800 | 12'(i * 7 + 100));

    // Handshake vector table
    for (int v = 0; v < 8; v++) begin
      bus.ld_valid = vecs[v].valid;
      bus.ld_frame = vecs[v].frame;
      bus.ld_index = vecs[v].index;
      bus.ld_data  = vecs[v].data;
      bus.start    = vecs[v].start;
      bus.stop     = vecs[v].stop;
      tick();
      bus.ld_valid = 1'b0;
      check($sformatf("vec%0d_ld_ready", v), 32'(bus.ld_ready), 32'(vecs[v].exp_ready));
      check($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_wr_en", v), 32'(bus.wr_en), 32'(vecs[v].exp_wr_en));
      check($sformatf("vec%0d_wr_index", v), 32'(bus.wr_index), 32'(vecs[v].exp_wr_index));
      check($sformatf("vec%0d_reload", v), 32'(bus.reload_req), 32'(vecs[v].exp_reload));
    end

    // Single-frame playback, falls every 1250 cycles, period 1
    bus.cfg_last_frame = 2'd0;
    bus.cfg_period     = 16'd1;
    fall_gap           = 1250;
    bus.start          = 1'b1;
    tick();
    check_stream(0, -1);
    fc = fall_cnt_tb;
    wait_reload(1400);
    check("t2_falls_to_reload", 32'(fall_cnt_tb - fc), 32'd1);
    tick();
    check("t2_reload_width", 32'(bus.reload_req), 32'd0);
    check_stream(0, -1);
    fc = fall_cnt_tb;
    wait_reload(1400);
    check("t2_falls_to_reload2", 32'(fall_cnt_tb - fc), 32'd1);
    check("t2_frame_wrap", 32'(bus.frame_idx), 32'd0);
    bus.stop = 1'b1;
    tick();
    check("t2_stop_busy", 32'(bus.busy), 32'd0);

    // Two-frame loop, reload every 3rd fall
    bus.cfg_last_frame = 2'd1;
    bus.cfg_period     = 16'd3;
    fall_gap           = 200;
    bus.start          = 1'b1;
    tick();
    check_stream(0, -1);
    fc = fall_cnt_tb;
    wait_reload(500);
    check("t3_first_reload_falls", 32'(fall_cnt_tb - fc), 32'd1);
    check("t3_frame_a", 32'(bus.frame_idx), 32'd1);
    fc = fall_cnt_tb;
    check_stream(1, -1);
    wait_reload(800);
    check("t3_period_falls_a", 32'(fall_cnt_tb - fc), 32'd3);
    check("t3_frame_b", 32'(bus.frame_idx), 32'd0);
    fc = fall_cnt_tb;
    check_stream(0, -1);
    wait_reload(800);
    check("t3_period_falls_b", 32'(fall_cnt_tb - fc), 32'd3);
    check("t3_frame_c", 32'(bus.frame_idx), 32'd1);
    check("t3_no_overrun", 32'(bus.overrun), 32'd0);
    bus.stop = 1'b1;
    tick();
    check("t3_stop_busy", 32'(bus.busy), 32'd0);

    // Stop in the middle of a stream
    bus.cfg_last_frame = 2'd0;
    bus.cfg_period     = 16'd1;
    fall_gap           = 50;
    bus.start          = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      if (bus.wr_en && bus.wr_index == 7'd40) break;
      tick();
    end
    check("t4_reached_40", 32'(bus.wr_index), 32'd40);
    bus.stop = 1'b1;
    tick();
    check("t4_wr_en_off", 32'(bus.wr_en), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_ld_ready", 32'(bus.ld_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.reload_req || bus.wr_en || bus.busy) seen = 1'b1;
    end
    check("t4_quiet_after_stop", 32'(seen), 32'd0);

    // Overrun: fall during a non-first stream with period 1
    fall_gap   = 0;
    bus.start  = 1'b1;
    tick();
    check_stream(0, -1);
    bus.main_clk_fall = 1'b1;
    wait_reload(5);
    check_stream(0, 10);
    check("t5_overrun", 32'(bus.overrun), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.reload_req) seen = 1'b1;
    end
    check("t5_no_early_reload", 32'(seen), 32'd0);
    bus.main_clk_fall = 1'b1;
    wait_reload(5);
    check_stream(0, -1);
    check("t5_overrun_sticky", 32'(bus.overrun), 32'd1);
    bus.stop = 1'b1;
    tick();

    // Load stalled by a stream, then out-of-range index dropped
    bus.cfg_last_frame = 2'd1;
    bus.cfg_period     = 16'd1;
    bus.start          = 1'b1;
    tick();
    check("t6_overrun_cleared", 32'(bus.overrun), 32'd0);
    bus.ld_valid = 1'b1;
    bus.ld_frame = 2'd0;
    bus.ld_index = 7'd5;
    bus.ld_data  = 12'hABC;
    stall = 0;
    while (!bus.ld_ready && stall < 200) begin
      tick();
      stall++;
    end
    check("t6_stall_cycles", 32'(stall), 32'(OUTPUTS + 1));
    check("t6_armed_busy", 32'(bus.busy), 32'd1);
    tick();
    model[0][5]  = 12'hABC;
    bus.ld_index = 7'd100;
    bus.ld_data  = 12'hFFF;
    tick();
    bus.ld_valid = 1'b0;
    bus.main_clk_fall = 1'b1;
    wait_reload(5);
    check_stream(1, -1);
    bus.main_clk_fall = 1'b1;
    wait_reload(5);
    check_stream(0, -1);

    // Reset in the middle of a stream
    bus.main_clk_fall = 1'b1;
    wait_reload(5);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_wr_en", 32'(bus.wr_en), 32'd0);
    check("t7_wr_index", 32'(bus.wr_index), 32'd0);
    check("t7_frame_idx", 32'(bus.frame_idx), 32'd0);
    check("t7_ld_ready", 32'(bus.ld_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
